// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types and helpers for the register slave.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  localparam int AXIL_STRB_W = 4;

  // Byte address to 32-bit word index; the two lane-select bits are dropped.
  function automatic int addr_to_idx(input logic [31:0] addr);
    return int'(addr >> 2);
  endfunction

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [AXIL_STRB_W-1:0] strb);
    logic [31:0] merged;
    merged = old_v;
    for (int k = 0; k < AXIL_STRB_W; k++) begin
      if (strb[k]) merged[8*k +: 8] = new_v[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_hold_stage.sv
// One-entry capture register for a valid/ready channel. Accepts one beat,
// holds it until the consumer clears it, and refuses input while blocked.
module axil_hold_stage #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  input  logic         i_block,
  input  logic         i_clear,
  output logic         o_held,
  output logic [W-1:0] o_data
);

  logic         r_held;
  logic [W-1:0] r_data;
  logic         w_fire;

  // Ready is forced low during reset so no beat is taken while the slave is idle-forced.
  assign o_ready = i_rst_n & ~r_held & ~i_block;
  assign w_fire  = i_valid & o_ready;
  assign o_held  = r_held;
  assign o_data  = r_data;

  // Held flag: set on handshake, dropped when the consumer has used the beat.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_held <= 1'b0;
    end else if (i_clear) begin
      r_held <= 1'b0;
    end else if (w_fire) begin
      r_held <= 1'b1;
    end
  end

  // Payload capture; only meaningful while r_held is set, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (w_fire) r_data <= i_data;
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers, with byte strobes,
// SLVERR for unimplemented addresses and a parallel copy of all registers.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                               S_AXI_ACLK,
  input  logic                               S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
  input  logic [2:0]                         S_AXI_AWPROT,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
  input  logic [AXIL_STRB_W-1:0]             S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

  logic [NUM_REGS*DW-1:0]        r_regs;
  logic                          r_bvalid;
  logic [1:0]                    r_bresp;
  logic                          r_rvalid;
  logic [1:0]                    r_rresp;
  logic [DW-1:0]                 r_rdata;

  logic                          w_aw_held;
  logic                          w_w_held;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_awaddr;
  logic [DW-1:0]                 w_wdata;
  logic [AXIL_STRB_W-1:0]        w_wstrb;
  logic                          w_commit;
  int                            w_aw_idx;
  logic                          w_aw_in_range;
  int                            w_ar_idx;
  logic                          w_ar_fire;
  logic [DW-1:0]                 w_rd_val;
  logic                          w_unused;

  // Protection bits carry no meaning for this register file.
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  axil_hold_stage #(.W(C_S_AXI_ADDR_WIDTH)) u_aw_hold (
    .i_clk   (S_AXI_ACLK),
    .i_rst_n (S_AXI_ARESETN),
    .i_valid (S_AXI_AWVALID),
    .o_ready (S_AXI_AWREADY),
    .i_data  (S_AXI_AWADDR),
    .i_block (r_bvalid),
    .i_clear (w_commit),
    .o_held  (w_aw_held),
    .o_data  (w_awaddr)
  );

  axil_hold_stage #(.W(DW + AXIL_STRB_W)) u_w_hold (
    .i_clk   (S_AXI_ACLK),
    .i_rst_n (S_AXI_ARESETN),
    .i_valid (S_AXI_WVALID),
    .o_ready (S_AXI_WREADY),
    .i_data  ({S_AXI_WDATA, S_AXI_WSTRB}),
    .i_block (r_bvalid),
    .i_clear (w_commit),
    .o_held  (w_w_held),
    .o_data  ({w_wdata, w_wstrb})
  );

  assign w_commit      = w_aw_held & w_w_held & ~r_bvalid;
  assign w_aw_idx      = addr_to_idx(32'(w_awaddr));
  assign w_aw_in_range = (w_aw_idx < NUM_REGS);

  // Register file update: strobed merge into the addressed word on commit.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_regs <= '0;
    end else if (w_commit && w_aw_in_range) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_aw_idx == i) r_regs[i*DW +: DW] <= strb_merge(r_regs[i*DW +: DW], w_wdata, w_wstrb);
      end
    end
  end

  // Write response: raised on commit, held until the master accepts it.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_bvalid <= 1'b0;
      r_bresp  <= OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_aw_in_range ? OKAY : SLVERR;
    end else if (r_bvalid && S_AXI_BREADY) begin
      r_bvalid <= 1'b0;
    end
  end

  assign S_AXI_ARREADY = S_AXI_ARESETN & ~r_rvalid;
  assign w_ar_fire     = S_AXI_ARVALID & S_AXI_ARREADY;
  assign w_ar_idx      = addr_to_idx(32'(S_AXI_ARADDR));

  // Read mux; unimplemented indices fall through to zero.
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == i) w_rd_val = r_regs[i*DW +: DW];
    end
  end

  // Read response: registered on AR handshake, held until the master accepts it.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_rvalid <= 1'b0;
      r_rresp  <= OKAY;
      r_rdata  <= '0;
    end else if (w_ar_fire) begin
      r_rvalid <= 1'b1;
      r_rresp  <= (w_ar_idx < NUM_REGS) ? OKAY : SLVERR;
      r_rdata  <= w_rd_val;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  assign S_AXI_BVALID = r_bvalid;
  assign S_AXI_BRESP  = r_bresp;
  assign S_AXI_RVALID = r_rvalid;
  assign S_AXI_RRESP  = r_rresp;
  assign S_AXI_RDATA  = r_rdata;
  assign reg_out      = r_regs;

endmodule
